// File: rtl/line_scan_ctrl.sv
// Line/frame sequencer for the composite video path: walks each line through its phases,
// addresses the line buffer during active video and ping-pongs the displayed buffer half.
// Build option: define LINE_SCAN_BURST_EN to include the colour burst phase.
//
// state  | meaning
// IDLE   | stopped, blanking level, waiting for enable
// SYNC   | horizontal sync tip
// BREEZE | breezeway after sync
// BURST  | colour burst window (LINE_SCAN_BURST_EN builds only)
// BACK   | back porch
// ACTIVE | displayed pixels, pixel_ptr walks the line buffer
// FRONT  | front porch; line boundary decision at its last clock
module line_scan_ctrl #(
  parameter int CLK_PER_PIX = 4,
  parameter int SYNC_LEN    = 40,
  parameter int BREEZE_LEN  = 8,
  parameter int BURST_LEN   = 36,
  parameter int BACK_LEN    = 20,
  parameter int ACTIVE_PIX  = 320,
  parameter int FRONT_LEN   = 24,
  parameter int LINES       = 262
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [8:0] pixel_ptr,
  output logic       pix_valid,
  output logic       sync,
  output logic       blank,
  output logic       burst,
  output logic [8:0] line_num,
  output logic       line_start,
  output logic       frame_start,
  output logic       buf_sel
);

`ifdef LINE_SCAN_BURST_EN
  localparam int BACK_TOTAL = BACK_LEN;
`else
  // Without a burst phase the back porch absorbs its time so the line length is unchanged.
  localparam int BACK_TOTAL = BURST_LEN + BACK_LEN;
`endif

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_LEN = max2(max2(max2(SYNC_LEN, BREEZE_LEN), max2(BURST_LEN, BACK_TOTAL)),
                                FRONT_LEN);
  localparam int PH_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PD_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

  localparam logic [PH_W-1:0] SYNC_LAST   = PH_W'(SYNC_LEN - 1);
  localparam logic [PH_W-1:0] BREEZE_LAST = PH_W'(BREEZE_LEN - 1);
`ifdef LINE_SCAN_BURST_EN
  localparam logic [PH_W-1:0] BURST_LAST  = PH_W'(BURST_LEN - 1);
`endif
  localparam logic [PH_W-1:0] BACK_LAST   = PH_W'(BACK_TOTAL - 1);
  localparam logic [PH_W-1:0] FRONT_LAST  = PH_W'(FRONT_LEN - 1);
  localparam logic [PD_W-1:0] PD_LAST     = PD_W'(CLK_PER_PIX - 1);
  localparam logic [8:0]      PTR_LAST    = 9'(ACTIVE_PIX - 1);
  localparam logic [8:0]      LINE_LAST   = 9'(LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    BREEZE,
`ifdef LINE_SCAN_BURST_EN
    BURST,
`endif
    BACK,
    ACTIVE,
    FRONT
  } stateT;

  stateT           state;
  logic [PH_W-1:0] phaseCnt;
  logic [PD_W-1:0] pixDiv;
  logic [8:0]      nextLine;

  assign nextLine = (line_num == LINE_LAST) ? 9'd0 : line_num + 9'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phaseCnt    <= '0;
      pixDiv      <= '0;
      pixel_ptr   <= 9'd0;
      pix_valid   <= 1'b0;
      sync        <= 1'b0;
      blank       <= 1'b1;
      burst       <= 1'b0;
      line_num    <= 9'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      buf_sel     <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= SYNC;
            phaseCnt    <= '0;
            line_num    <= 9'd0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            sync        <= 1'b1;
            blank       <= 1'b1;
          end
        end
        SYNC: begin
          if (phaseCnt == SYNC_LAST) begin
            state    <= BREEZE;
            phaseCnt <= '0;
            sync     <= 1'b0;
          end else begin
            phaseCnt <= phaseCnt + PH_W'(1);
          end
        end
        BREEZE: begin
          if (phaseCnt == BREEZE_LAST) begin
            phaseCnt <= '0;
`ifdef LINE_SCAN_BURST_EN
            state    <= BURST;
            burst    <= 1'b1;
`else
            state    <= BACK;
`endif
          end else begin
            phaseCnt <= phaseCnt + PH_W'(1);
          end
        end
`ifdef LINE_SCAN_BURST_EN
        BURST: begin
          if (phaseCnt == BURST_LAST) begin
            state    <= BACK;
            phaseCnt <= '0;
            burst    <= 1'b0;
          end else begin
            phaseCnt <= phaseCnt + PH_W'(1);
          end
        end
`endif
        BACK: begin
          if (phaseCnt == BACK_LAST) begin
            state     <= ACTIVE;
            phaseCnt  <= '0;
            pixDiv    <= '0;
            pixel_ptr <= 9'd0;
            pix_valid <= 1'b1;
            blank     <= 1'b0;
          end else begin
            phaseCnt <= phaseCnt + PH_W'(1);
          end
        end
        ACTIVE: begin
          if (pixDiv == PD_LAST) begin
            pixDiv <= '0;
            if (pixel_ptr == PTR_LAST) begin
              // Displayed half is finished: hand it back to the writer.
              state     <= FRONT;
              phaseCnt  <= '0;
              pixel_ptr <= 9'd0;
              pix_valid <= 1'b0;
              blank     <= 1'b1;
              buf_sel   <= ~buf_sel;
            end else begin
              pixel_ptr <= pixel_ptr + 9'd1;
            end
          end else begin
            pixDiv <= pixDiv + PD_W'(1);
          end
        end
        FRONT: begin
          if (phaseCnt == FRONT_LAST) begin
            phaseCnt <= '0;
            if (enable) begin
              state       <= SYNC;
              line_num    <= nextLine;
              line_start  <= 1'b1;
              frame_start <= (nextLine == 9'd0);
              sync        <= 1'b1;
            end else begin
              state    <= IDLE;
              line_num <= 9'd0;
            end
          end else begin
            phaseCnt <= phaseCnt + PH_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          phaseCnt  <= '0;
          pixDiv    <= '0;
          pixel_ptr <= 9'd0;
          pix_valid <= 1'b0;
          sync      <= 1'b0;
          blank     <= 1'b1;
          burst     <= 1'b0;
          line_num  <= 9'd0;
        end
      endcase
    end
  end

endmodule
